// File: rtl/datapath_seq_pkg.sv
// Shared encodings for the sequential datapath: ALU ops, B-shift modes,
// writeback source select, controller states and status-bit positions.
package datapath_seq_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    VSEL_C     = 2'b00,
    VSEL_PC    = 2'b01,
    VSEL_IMM8  = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXE  = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  // Bit positions inside the 3-bit status register.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/datapath_seq_if.sv
// Command/result bundle of the sequential datapath. The master issues
// commands and observes results; the slave is the datapath itself.
interface datapath_seq_if #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 9
);
  localparam int RW = $clog2(NREG);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_alu_op;
  logic [1:0]     cmd_shift;
  logic [RW-1:0]  cmd_rn;
  logic [RW-1:0]  cmd_rm;
  logic [RW-1:0]  cmd_rd;
  logic           cmd_asel;
  logic           cmd_bsel;
  logic [1:0]     cmd_vsel;
  logic           cmd_loads;
  logic           cmd_write;
  logic [W-1:0]   sximm5;
  logic [W-1:0]   sximm8;
  logic [W-1:0]   mdata;
  logic [PCW-1:0] PC;
  logic           done;
  logic [W-1:0]   datapath_out;
  logic [2:0]     Z_out;

  modport master (
    output cmd_valid, cmd_alu_op, cmd_shift, cmd_rn, cmd_rm, cmd_rd,
           cmd_asel, cmd_bsel, cmd_vsel, cmd_loads, cmd_write,
           sximm5, sximm8, mdata, PC,
    input  cmd_ready, done, datapath_out, Z_out
  );

  modport slave (
    input  cmd_valid, cmd_alu_op, cmd_shift, cmd_rn, cmd_rm, cmd_rd,
           cmd_asel, cmd_bsel, cmd_vsel, cmd_loads, cmd_write,
           sximm5, sximm8, mdata, PC,
    output cmd_ready, done, datapath_out, Z_out
  );

endinterface

// File: rtl/datapath_seq_regfile_p.sv
// NREG x W register file: two combinational read ports, one synchronous
// write port. Reset clears every entry and wins over a write in the same cycle.
module regfile_p #(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [$clog2(NREG)-1:0]   wa,
  input  logic signed [W-1:0]       wd,
  input  logic [$clog2(NREG)-1:0]   ra0,
  output logic signed [W-1:0]       rd0,
  input  logic [$clog2(NREG)-1:0]   ra1,
  output logic signed [W-1:0]       rd1
);

  logic signed [W-1:0] mem [NREG];

  // Clear on reset, otherwise write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle datapath: a command is latched on acceptance, operands are read
// one per cycle (RDA, RDB), the ALU result lands in C in EXE, and the selected
// writeback value goes to the register file on the edge leaving WB.
// Commands that write back PC/sximm8/mdata skip straight to WB.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 9
) (
  input  logic          clk,
  input  logic          reset,
  datapath_seq_if.slave bus
);

  localparam int RW = $clog2(NREG);

  // Controller state and registered handshake outputs
  state_e              state;
  logic                ready_q;
  logic                done_q;

  // Command captured at acceptance
  alu_op_e             op_q;
  shift_e              sh_q;
  vsel_e               vsel_q;
  logic [RW-1:0]       rn_q;
  logic [RW-1:0]       rm_q;
  logic [RW-1:0]       rd_q;
  logic                asel_q;
  logic                bsel_q;
  logic                loads_q;
  logic                write_q;
  logic signed [W-1:0] imm5_q;
  logic signed [W-1:0] imm8_q;
  logic signed [W-1:0] mdata_q;
  logic [PCW-1:0]      pc_q;

  // Architectural datapath registers
  logic signed [W-1:0] a_q;
  logic signed [W-1:0] b_q;
  logic signed [W-1:0] c_q;
  logic [2:0]          status_q;

  logic signed [W-1:0] rf_rd0;
  logic signed [W-1:0] rf_rd1;
  logic signed [W-1:0] alu_a;
  logic signed [W-1:0] alu_b;
  logic signed [W-1:0] alu_r;
  logic [2:0]          alu_flags;
  logic signed [W-1:0] wb_data;
  logic                rf_we;
  logic                accept;

  function automatic logic signed [W-1:0] shift_f(input shift_e sh,
                                                  input logic signed [W-1:0] b);
    case (sh)
      SH_LSL1: return {b[W-2:0], 1'b0};
      SH_LSR1: return {1'b0, b[W-1:1]};
      SH_ASR1: return {b[W-1], b[W-1:1]};
      default: return b;
    endcase
  endfunction

  function automatic logic signed [W-1:0] alu_f(input alu_op_e op,
                                                input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return ~b;
    endcase
  endfunction

  // Overflow compares operand and result signs; logic ops never overflow.
  function automatic logic [2:0] flags_f(input alu_op_e op,
                                         input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b,
                                         input logic signed [W-1:0] r);
    logic [2:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[W-1];
    case (op)
      ALU_ADD: f[FLAG_V] = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      ALU_SUB: f[FLAG_V] = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      default: f[FLAG_V] = 1'b0;
    endcase
    return f;
  endfunction

  assign accept = bus.cmd_valid && ready_q;
  assign rf_we  = (state == ST_WB) && write_q;

  regfile_p #(
    .W    (W),
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .wa    (rd_q),
    .wd    (wb_data),
    .ra0   (rn_q),
    .rd0   (rf_rd0),
    .ra1   (rm_q),
    .rd1   (rf_rd1)
  );

  // ALU operand selection, result and flags for the EXE cycle.
  always_comb begin
    alu_a     = asel_q ? '0 : a_q;
    alu_b     = bsel_q ? imm5_q : shift_f(sh_q, b_q);
    alu_r     = alu_f(op_q, alu_a, alu_b);
    alu_flags = flags_f(op_q, alu_a, alu_b, alu_r);
  end

  // Writeback source mux; PC is zero-extended to the data width.
  always_comb begin
    wb_data = '0;
    case (vsel_q)
      VSEL_C:    wb_data = c_q;
      VSEL_PC:   wb_data[PCW-1:0] = pc_q;
      VSEL_IMM8: wb_data = imm8_q;
      default:   wb_data = mdata_q;
    endcase
  end

  // Capture the whole command when it is accepted so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= alu_op_e'(bus.cmd_alu_op);
      sh_q    <= shift_e'(bus.cmd_shift);
      vsel_q  <= vsel_e'(bus.cmd_vsel);
      rn_q    <= bus.cmd_rn;
      rm_q    <= bus.cmd_rm;
      rd_q    <= bus.cmd_rd;
      asel_q  <= bus.cmd_asel;
      bsel_q  <= bus.cmd_bsel;
      loads_q <= bus.cmd_loads;
      write_q <= bus.cmd_write;
      imm5_q  <= bus.sximm5;
      imm8_q  <= bus.sximm8;
      mdata_q <= bus.mdata;
      pc_q    <= bus.PC;
    end
  end

  // Controller: sequences IDLE/RDA/RDB/EXE/WB and updates A, B, C and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (vsel_e'(bus.cmd_vsel) == VSEL_C) begin
              state <= ST_RDA;
            end else begin
              state  <= ST_WB;
              done_q <= 1'b1;
            end
          end
        end
        ST_RDA: begin
          a_q   <= rf_rd0;
          state <= ST_RDB;
        end
        ST_RDB: begin
          b_q   <= rf_rd1;
          state <= ST_EXE;
        end
        ST_EXE: begin
          c_q <= alu_r;
          if (loads_q) begin
            status_q <= alu_flags;
          end
          state  <= ST_WB;
          done_q <= 1'b1;
        end
        ST_WB: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.done         = done_q;
  assign bus.datapath_out = c_q;
  assign bus.Z_out        = status_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: the driver issues commands, a reference
// model predicts C/status/latency and queues them, and a monitor checks each
// done pulse against the queue head.
module tb_datapath_seq;

  localparam int W    = 16;
  localparam int NREG = 8;
  localparam int PCW  = 9;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic        loads;
    logic        write;
    logic [15:0] imm5;
    logic [15:0] imm8;
    logic [15:0] md;
    logic [8:0]  pc;
  } cmd_t;

  typedef struct packed {
    logic [15:0] c;
    logic [2:0]  z;
    int          acc;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  logic [15:0] m_rf [NREG];
  logic [15:0] m_c;
  logic [2:0]  m_st;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datapath_seq_if #(.W(W), .NREG(NREG), .PCW(PCW)) bus ();

  datapath_seq #(.W(W), .NREG(NREG), .PCW(PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cmd_t zero_cmd();
    cmd_t c;
    c = '0;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op    = 2'($urandom_range(0, 3));
    c.sh    = 2'($urandom_range(0, 3));
    c.rn    = 3'($urandom_range(0, 7));
    c.rm    = 3'($urandom_range(0, 7));
    c.rd    = 3'($urandom_range(0, 7));
    c.asel  = ($urandom_range(0, 3) == 0);
    c.bsel  = ($urandom_range(0, 3) == 0);
    c.vsel  = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
    c.loads = 1'($urandom_range(0, 1));
    c.write = ($urandom_range(0, 3) != 0);
    c.imm5  = 16'($urandom);
    c.imm8  = 16'($urandom);
    c.md    = 16'($urandom);
    c.pc    = 9'($urandom);
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    bus.cmd_alu_op = c.op;
    bus.cmd_shift  = c.sh;
    bus.cmd_rn     = c.rn;
    bus.cmd_rm     = c.rm;
    bus.cmd_rd     = c.rd;
    bus.cmd_asel   = c.asel;
    bus.cmd_bsel   = c.bsel;
    bus.cmd_vsel   = c.vsel;
    bus.cmd_loads  = c.loads;
    bus.cmd_write  = c.write;
    bus.sximm5     = c.imm5;
    bus.sximm8     = c.imm8;
    bus.mdata      = c.md;
    bus.PC         = c.pc;
  endtask

  // Reference model: signed integer arithmetic, overflow = true result out of range.
  task automatic model_exec(input cmd_t c, output logic [15:0] c_out, output logic [2:0] st_out);
    logic [15:0] a, b, ai, bi, r, wval;
    int sa, sbv, sr;
    logic v;
    if (c.vsel == 2'b00) begin
      a  = m_rf[c.rn];
      b  = m_rf[c.rm];
      ai = c.asel ? 16'd0 : a;
      case (c.sh)
        2'd1:    bi = 16'(b * 2);
        2'd2:    bi = b / 2;
        2'd3:    bi = (b / 2) + (b[15] ? 16'h8000 : 16'h0000);
        default: bi = b;
      endcase
      if (c.bsel) bi = c.imm5;
      sa  = int'($signed(ai));
      sbv = int'($signed(bi));
      v   = 1'b0;
      case (c.op)
        2'd0: begin sr = sa + sbv; r = 16'(sr); v = (sr > 32767) || (sr < -32768); end
        2'd1: begin sr = sa - sbv; r = 16'(sr); v = (sr > 32767) || (sr < -32768); end
        2'd2: r = ai & bi;
        default: r = ~bi;
      endcase
      m_c = r;
      if (c.loads) m_st = {v, r[15], (r == 16'd0)};
    end
    case (c.vsel)
      2'd0:    wval = m_c;
      2'd1:    wval = {7'd0, c.pc};
      2'd2:    wval = c.imm8;
      default: wval = c.md;
    endcase
    if (c.write) m_rf[c.rd] = wval;
    c_out  = m_c;
    st_out = m_st;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_rf[i] = 16'd0;
    m_c  = 16'd0;
    m_st = 3'd0;
  endtask

  // Wait (bounded) for cmd_ready at a falling edge; returns 1 when ready.
  task automatic wait_ready(output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = (bus.cmd_ready === 1'b1);
    if (!ok) chk("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic issue(input cmd_t c, input bit hold);
    exp_t e;
    bit ok;
    bit seen;
    wait_ready(ok);
    if (!ok) return;
    drive(c);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    model_exec(c, e.c, e.z);
    e.acc = cyc;
    e.lat = (c.vsel == 2'b00) ? 3 : 0;
    sb.push_back(e);
    if (!hold) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      drive(rand_cmd());
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        drive(rand_cmd());
        chk("ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      bus.cmd_valid = 1'b0;
      if (!seen) chk("hold_done_seen", 32'd0, 32'd1);
      @(negedge clk);
      chk("ready_after_wb", {31'd0, bus.cmd_ready}, 32'd1);
    end
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [15:0] val);
    cmd_t c;
    c = zero_cmd();
    c.vsel = 2'b10; c.imm8 = val; c.rd = r; c.write = 1'b1;
    issue(c, 1'b0);
  endtask

  // C <- 0 + R[r], status untouched: makes a register observable.
  task automatic read_reg(input logic [2:0] r);
    cmd_t c;
    c = zero_cmd();
    c.op = 2'b00; c.asel = 1'b1; c.rm = r;
    issue(c, 1'b0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (mon_en && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no command in flight (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("datapath_out", {16'd0, bus.datapath_out}, {16'd0, mon_e.c});
        chk("Z_out", {29'd0, bus.Z_out}, {29'd0, mon_e.z});
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_t c;
    bit ok;
    int w;
    bus.cmd_valid = 1'b0;
    drive(zero_cmd());
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_c", {16'd0, bus.datapath_out}, 32'd0);
    chk("rst_status", {29'd0, bus.Z_out}, 32'd0);
    mon_en = 1'b1;

    // Immediate write, then read back
    load_reg(3'd1, 16'h0007);
    read_reg(3'd1);

    // Signed overflow on ADD
    load_reg(3'd1, 16'h7FFF);
    load_reg(3'd2, 16'h0001);
    c = zero_cmd(); c.op = 2'b00; c.rn = 3'd1; c.rm = 3'd2; c.rd = 3'd3; c.loads = 1'b1; c.write = 1'b1;
    issue(c, 1'b0);
    read_reg(3'd3);

    // Zero result on SUB without writeback
    load_reg(3'd1, 16'h0005);
    load_reg(3'd2, 16'h0005);
    c = zero_cmd(); c.op = 2'b01; c.rn = 3'd1; c.rm = 3'd2; c.rd = 3'd3; c.loads = 1'b1;
    issue(c, 1'b0);
    read_reg(3'd1);
    read_reg(3'd2);
    read_reg(3'd3);

    // Shift modes on a negative operand
    load_reg(3'd4, 16'h8002);
    c = zero_cmd(); c.op = 2'b11; c.sh = 2'b11; c.rm = 3'd4; c.loads = 1'b1;
    issue(c, 1'b0);
    c = zero_cmd(); c.op = 2'b00; c.asel = 1'b1; c.sh = 2'b10; c.rm = 3'd4;
    issue(c, 1'b0);
    c = zero_cmd(); c.op = 2'b00; c.asel = 1'b1; c.sh = 2'b01; c.rm = 3'd4; c.loads = 1'b1;
    issue(c, 1'b0);

    // Held valid with inputs changing mid-command
    c = zero_cmd(); c.vsel = 2'b11; c.md = 16'hBEEF; c.rd = 3'd5; c.write = 1'b1;
    issue(c, 1'b1);
    c = zero_cmd(); c.vsel = 2'b01; c.pc = 9'h1A5; c.rd = 3'd6; c.write = 1'b1;
    issue(c, 1'b1);
    c = zero_cmd(); c.op = 2'b01; c.rn = 3'd5; c.rm = 3'd6; c.rd = 3'd5; c.loads = 1'b1; c.write = 1'b1;
    issue(c, 1'b1);
    read_reg(3'd5);

    // Randomized commands
    for (int i = 0; i < 150; i++) begin
      issue(rand_cmd(), ($urandom_range(0, 3) == 0));
    end

    // Reset during EXE of a writing command aborts it
    load_reg(3'd5, 16'h1234);
    c = zero_cmd(); c.op = 2'b01; c.asel = 1'b1; c.rm = 3'd5; c.loads = 1'b1;
    issue(c, 1'b0);
    wait_ready(ok);
    if (ok) begin
      c = zero_cmd(); c.op = 2'b00; c.rn = 3'd5; c.rm = 3'd5; c.rd = 3'd6; c.loads = 1'b1; c.write = 1'b1;
      drive(c);
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_status", {29'd0, bus.Z_out}, 32'd0);
      chk("abort_c", {16'd0, bus.datapath_out}, 32'd0);
    end
    read_reg(3'd6);
    read_reg(3'd5);

    for (int i = 0; i < 40; i++) begin
      issue(rand_cmd(), ($urandom_range(0, 3) == 0));
    end

    // Drain outstanding predictions
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 Parameter W, default 16, data-path width in bits (≥4).
REQ-002 Parameter NREG, default 8, register-file depth; a power of 2, ≥2; RW = log2(NREG).
REQ-003 Parameter PCW, default 9, program-counter width; PCW ≤ W.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; accepted on an edge where both are 1.
REQ-007 cmd_alu_op  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 NOT-B.
REQ-008 cmd_shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1 (msb←0), 11 ASR1 (msb kept).
REQ-009 cmd_rn, cmd_rm, cmd_rd  in  RW each  A-source, B-source and destination register.
REQ-010 cmd_asel / cmd_bsel  in  1 / 1  A←0 when 1 / B←sximm5 when 1.
REQ-011 cmd_vsel  in  2  writeback source: 00 C, 01 PC zero-extended, 10 sximm8, 11 mdata.
REQ-012 cmd_loads / cmd_write  in  1 / 1  update status / write rd at writeback.
REQ-013 sximm5, sximm8, mdata  in  W each  immediate and memory operands.
REQ-014 PC  in  PCW  program counter.
REQ-015 done  out  1  one-cycle pulse in the writeback cycle.
REQ-016 datapath_out  out  W  C register.
REQ-017 Z_out  out  3  status register: [0] zero, [1] negative, [2] overflow.

Function
REQ-018 All cmd_* fields, sximm5, sximm8, mdata and PC are latched at acceptance; later input changes do not affect the command in flight.
REQ-019 FSM states: IDLE, RDA, RDB, EXE, WB; cmd_ready = 1 only in IDLE.
REQ-020 IDLE: on acceptance go to RDA if vsel = 00, else go directly to WB; with no acceptance stay in IDLE.
REQ-021 RDA: A ← R[rn]; go to RDB.
REQ-022 RDB: B ← R[rm]; go to EXE.
REQ-023 EXE: C ← ALU(asel ? 0 : A, bsel ? sximm5 : shift(B)); when loads = 1, status ← flags of that result; go to WB.
REQ-024 WB: done = 1; when write = 1, R[rd] ← selected source at the edge leaving WB; go to IDLE.
REQ-025 Latency: acceptance at edge k gives done high in the cycle after edge k+3 (vsel = 00) or after edge k (vsel ≠ 00); the written value is readable from the edge after that.
REQ-026 Arithmetic is modulo 2^W; PC is zero-extended to W.
REQ-027 Flags: Z = (result == 0); N = result[W-1].
REQ-028 V for ADD = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]).
REQ-029 V for SUB = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]).
REQ-030 V = 0 for AND and NOT-B.
REQ-031 vsel ≠ 00 commands leave A, B, C and status unchanged.
REQ-032 cmd_valid while cmd_ready = 0 has no effect; the command is not queued.
REQ-033 rd may equal rn or rm; reads complete before the WB write.

Reset
REQ-034 reset has priority over every other input in the same cycle.
REQ-035 On reset: FSM → IDLE; A, B, C, status and all NREG registers → 0; done = 0; cmd_ready = 1 in the following cycle.
REQ-036 Reset asserted mid-operation aborts the command; no register-file write occurs.

Structure
REQ-037 A shared package holds the ALU-op, shift and vsel encodings and the FSM state enum.
REQ-038 The register file is one sub-module, regfile_p, parametrised by W and NREG, with synchronous write and combinational read.

Verification
REQ-039 Reset, then vsel=10, sximm8=0x0007, rd=R1, write=1 -> done one cycle after acceptance; R1=0x0007; status stays 000.
REQ-040 R1=0x7FFF, R2=0x0001; ADD rn=R1, rm=R2, rd=R3, loads=1 -> done in the 4th cycle after acceptance; R3=0x8000; Z_out=110.
REQ-041 SUB with R1=R2=0x0005, loads=1, write=0 -> C=0x0000; Z_out=001; no register changed.
REQ-042 ASR1 on B=0x8002 with NOT-B, bsel=0 -> C=0x3FFE; LSR1 on B=0x8002 -> shifted B=0x4001.
REQ-043 Hold cmd_valid=1 for the whole command and change sximm8 and mdata mid-command -> exactly one acceptance; cmd_ready=0 from acceptance until WB exits; the latched operands are used.
REQ-044 Assert reset in the EXE cycle of a write=1 command -> rd unchanged (0); FSM in IDLE; status=000.
